hazard_ctrl: RTL and testbench

- Central pipeline sequencing controller for the 5-stage core; sits beside the forwarding unit.
- Generates per-stage enable and flush controls for load-use stalls, EX-stage branch/jump redirects and data-memory wait states.
- Maintains stall/flush performance counters and a sticky memory-timeout flag.

---
 rtl/hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_hazard_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage core.
// Produces per-stage enables and flushes for data-memory waits, EX redirects
// and load-use stalls. It also keeps stall/flush performance counters and a
// sticky memory-timeout flag.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | pipeline advancing normally (branch / load-use handling)
// MWAIT | data-memory request outstanding, pipeline frozen until ack
module hazard_ctrl #(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       IFID_rs1_i,
  input  logic [4:0]       IFID_rs2_i,
  input  logic             IFID_rs1_used_i,
  input  logic             IFID_rs2_used_i,
  input  logic [4:0]       IDEX_rd_i,
  input  logic             IDEX_memrd_i,
  input  logic             EX_br_taken_i,
  input  logic             EXMEM_memreq_i,
  input  logic             dmem_ack_i,
  output logic             pc_en_o,
  output logic             IFID_en_o,
  output logic             IFID_flush_o,
  output logic             IDEX_en_o,
  output logic             IDEX_flush_o,
  output logic             EXMEM_en_o,
  output logic             MEMWB_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             err_timeout_o
);

  localparam int WAIT_W = 16;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0]  CNT_SAT  = {CNT_W{1'b1}};

  typedef enum logic {RUN = 1'b0, MWAIT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  logic              err_d;
  logic              mem_stall, load_use, redirect;

  assign mem_stall = EXMEM_memreq_i & ~dmem_ack_i;
  assign load_use  = IDEX_memrd_i && (IDEX_rd_i != 5'd0) &&
                     ((IFID_rs1_used_i && (IFID_rs1_i == IDEX_rd_i)) ||
                      (IFID_rs2_used_i && (IFID_rs2_i == IDEX_rd_i)));
  // A redirect only counts when the pipeline is actually advancing.
  assign redirect  = EX_br_taken_i & ~mem_stall;
  assign wait_inc  = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);

  // State, wait counter, timeout flag and performance counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= RUN;
      wait_q        <= '0;
      err_timeout_o <= 1'b0;
      stall_cnt_o   <= '0;
      flush_cnt_o   <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      err_timeout_o <= err_d;
      if (!pc_en_o && (stall_cnt_o != CNT_SAT)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (redirect && (flush_cnt_o != CNT_SAT)) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

  // Next state; wait_q holds the number of completed stall cycles of the
  // current access, so the first stall cycle (still in RUN) already counts.
  // The flag latches on the edge that completes the MAX_WAIT-th wait cycle.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MWAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      MWAIT: begin
        // A request dropping without ack is treated as a release.
        if (mem_stall) wait_d  = wait_inc;
        else           state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    err_d = err_timeout_o | (mem_stall && (wait_d == WAIT_MAX));
  end

  // Stage controls: memory wait > redirect > load-use > free-running.
  always_comb begin
    pc_en_o       = 1'b1;
    IFID_en_o     = 1'b1;
    IFID_flush_o  = 1'b0;
    IDEX_en_o     = 1'b1;
    IDEX_flush_o  = 1'b0;
    EXMEM_en_o    = 1'b1;
    MEMWB_flush_o = 1'b0;
    if (!rst_ni) begin
      pc_en_o       = 1'b0;
      IFID_en_o     = 1'b0;
      IDEX_en_o     = 1'b0;
      EXMEM_en_o    = 1'b0;
      IFID_flush_o  = 1'b1;
      IDEX_flush_o  = 1'b1;
      MEMWB_flush_o = 1'b1;
    end else if (mem_stall) begin
      pc_en_o       = 1'b0;
      IFID_en_o     = 1'b0;
      IDEX_en_o     = 1'b0;
      EXMEM_en_o    = 1'b0;
      MEMWB_flush_o = 1'b1;
    end else if (EX_br_taken_i) begin
      IFID_flush_o  = 1'b1;
      IDEX_flush_o  = 1'b1;
    end else if (load_use) begin
      pc_en_o       = 1'b0;
      IFID_en_o     = 1'b0;
      IDEX_flush_o  = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver applies directed and random
// stimulus and pushes the reference model's expectation; a monitor pops and
// compares at the falling edge.
module tb_hazard_ctrl;
  localparam int CNT_W    = 8;
  localparam int MAX_WAIT = 4;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic u1 = 0, u2 = 0, memrd = 0, br = 0, req = 0, ack = 0;
  logic pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, memwb_fl, err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .IFID_rs1_i(rs1), .IFID_rs2_i(rs2),
    .IFID_rs1_used_i(u1), .IFID_rs2_used_i(u2),
    .IDEX_rd_i(rd), .IDEX_memrd_i(memrd),
    .EX_br_taken_i(br), .EXMEM_memreq_i(req), .dmem_ack_i(ack),
    .pc_en_o(pc_en), .IFID_en_o(ifid_en), .IFID_flush_o(ifid_fl),
    .IDEX_en_o(idex_en), .IDEX_flush_o(idex_fl), .EXMEM_en_o(exmem_en),
    .MEMWB_flush_o(memwb_fl),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .err_timeout_o(err)
  );

  typedef struct packed {
    logic rst; logic [4:0] rs1, rs2; logic u1, u2; logic [4:0] rd;
    logic memrd, br, req, ack;
  } stim_t;

  typedef struct packed {
    logic [6:0] ctrl; logic [CNT_W-1:0] sc, fc; logic err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference model state: counters, length of the current memory wait, flag.
  int m_sc = 0, m_fc = 0, m_wait = 0;
  bit m_err = 0;

  function automatic stim_t nop();
    stim_t s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  // Drive one cycle of stimulus and queue the model's expectation for it.
  task automatic tick(input stim_t s);
    exp_t e;
    bit ms, lu, pc, ie, ifl, de, dfl, xe, mfl;
    @(posedge clk); #1;
    rst_n = s.rst; rs1 = s.rs1; rs2 = s.rs2; u1 = s.u1; u2 = s.u2;
    rd = s.rd; memrd = s.memrd; br = s.br; req = s.req; ack = s.ack;
    if (!s.rst) begin
      m_sc = 0; m_fc = 0; m_wait = 0; m_err = 0;
      e.ctrl = 7'b0010101;
      e.sc = '0; e.fc = '0; e.err = 1'b0;
    end else begin
      ms = s.req && !s.ack;
      lu = s.memrd && (s.rd != 0) &&
           ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
      pc = 1; ie = 1; ifl = 0; de = 1; dfl = 0; xe = 1; mfl = 0;
      if (ms) begin
        pc = 0; ie = 0; de = 0; xe = 0; mfl = 1;
      end else if (s.br) begin
        ifl = 1; dfl = 1;
      end else if (lu) begin
        pc = 0; ie = 0; dfl = 1;
      end
      e.ctrl = {pc, ie, ifl, de, dfl, xe, mfl};
      e.sc = CNT_W'(m_sc); e.fc = CNT_W'(m_fc); e.err = m_err;
      if (!pc && m_sc < CMAX) m_sc++;
      if (s.br && !ms && m_fc < CMAX) m_fc++;
      if (ms) begin
        m_wait++;
        if (m_wait >= MAX_WAIT) m_err = 1;
      end else begin
        m_wait = 0;
      end
    end
    sb.push_back(e);
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ctrl", 32'({pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, memwb_fl}), 32'(e.ctrl));
        chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
        chk("flush_cnt", 32'(flush_cnt), 32'(e.fc));
        chk("err_timeout", 32'(err), 32'(e.err));
      end
    end
  end

  initial begin
    stim_t s;
    s = nop(); s.rst = 0;
    repeat (2) tick(s);
    repeat (2) tick(nop());

    // Load-use on rs2, then the same with rd=x0.
    s = nop(); s.memrd = 1; s.rd = 5; s.rs2 = 5; s.u2 = 1;
    tick(s); tick(nop());
    s = nop(); s.memrd = 1; s.rd = 0; s.rs1 = 0; s.u1 = 1;
    tick(s); tick(nop());

    // Branch overrides load-use.
    s = nop(); s.memrd = 1; s.rd = 7; s.rs1 = 7; s.u1 = 1; s.br = 1;
    tick(s); tick(nop());

    // Three-cycle memory wait, then a zero-wait access.
    s = nop(); s.req = 1;
    repeat (3) tick(s);
    s.ack = 1; tick(s); tick(nop());
    tick(s); tick(nop());

    // Branch held through a two-cycle wait.
    s = nop(); s.req = 1; s.br = 1;
    repeat (2) tick(s);
    s.ack = 1; tick(s); tick(nop());

    // Timeout: six withheld acks, flag stays after release.
    s = nop(); s.req = 1;
    repeat (6) tick(s);
    s.ack = 1; tick(s);
    repeat (2) tick(nop());

    // Async reset in the middle of a wait, then a fresh short wait.
    s = nop(); s.req = 1;
    repeat (2) tick(s);
    s.rst = 0; tick(s);
    repeat (2) tick(nop());
    s = nop(); s.req = 1;
    repeat (3) tick(s);
    s.ack = 1; tick(s); tick(nop());

    // Random traffic; long enough for stall_cnt to saturate.
    for (int i = 0; i < 2000; i++) begin
      s = nop();
      s.rs1 = 5'($urandom_range(0, 3)); s.rs2 = 5'($urandom_range(0, 3));
      s.rd = 5'($urandom_range(0, 3));
      s.u1 = 1'($urandom); s.u2 = 1'($urandom); s.memrd = 1'($urandom);
      s.br = ($urandom_range(0, 3) == 0);
      s.req = 1'($urandom); s.ack = 1'($urandom);
      tick(s);
    end
    repeat (2) tick(nop());

    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
